// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART transmit path.
// Holds the arbiter state encoding and the standard bit-period constants.
package uart_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT
    } state_t;

    // Clock cycles per bit at the supported baud rates.
    localparam int CPB_9600        = 1042;
    localparam int CPB_19200       = 521;
    localparam int TIMEOUT_DEFAULT = 16383;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority select: the search starts one past the pointer
// and the first set request wins.
module rr_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    int cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = (int'(ptr) + i) % NUM_REQ;
            if (!any && req[cand]) begin
                any         = 1'b1;
                idx         = IDX_W'(cand);
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter between NUM_REQ producers.
// Optional TxDone watchdog is built when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic [NUM_REQ-1:0]         ReqValid,
    input  logic [8*NUM_REQ-1:0]       ReqData,
    output logic [NUM_REQ-1:0]         ReqReady,
    output logic                       TxDataLoad,
    output logic [7:0]                 TxDataIn,
    input  logic                       TxDone,
    output logic [$clog2(NUM_REQ)-1:0] GrantId,
    output logic                       Busy,
    output logic                       Timeout
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_REQ - 1);

    state_t             state;
    logic [IDX_W-1:0]   last;
    logic [NUM_REQ-1:0] win_onehot;
    logic [IDX_W-1:0]   win_idx;
    logic               win_any;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req   (ReqValid),
        .ptr   (last),
        .grant (win_onehot),
        .idx   (win_idx),
        .any   (win_any)
    );

    // Ready is gated by reset so no handshake can complete while held in reset.
    assign ReqReady = (Reset && state == IDLE) ? win_onehot : '0;

`ifdef UART_ARB_TIMEOUT_EN
    logic [13:0] wait_count;
    logic        expired;

    assign expired = (wait_count == 14'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            last       <= LAST_INIT;
            GrantId    <= '0;
            TxDataIn   <= '0;
            TxDataLoad <= 1'b0;
            Busy       <= 1'b0;
            Timeout    <= 1'b0;
            wait_count <= '0;
        end else begin
            TxDataLoad <= 1'b0;
            Timeout    <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_any) begin
                        state      <= LOAD;
                        last       <= win_idx;
                        GrantId    <= win_idx;
                        TxDataIn   <= ReqData[8*int'(win_idx) +: 8];
                        TxDataLoad <= 1'b1;
                        Busy       <= 1'b1;
                    end
                end
                LOAD: begin
                    state      <= WAIT;
                    wait_count <= '0;
                end
                WAIT: begin
                    // A TxDone coinciding with expiry is a normal completion.
                    if (TxDone) begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end else if (expired) begin
                        state   <= IDLE;
                        Busy    <= 1'b0;
                        Timeout <= 1'b1;
                    end else begin
                        wait_count <= wait_count + 14'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
    assign Timeout            = 1'b0;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            last       <= LAST_INIT;
            GrantId    <= '0;
            TxDataIn   <= '0;
            TxDataLoad <= 1'b0;
            Busy       <= 1'b0;
        end else begin
            TxDataLoad <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_any) begin
                        state      <= LOAD;
                        last       <= win_idx;
                        GrantId    <= win_idx;
                        TxDataIn   <= ReqData[8*int'(win_idx) +: 8];
                        TxDataLoad <= 1'b1;
                        Busy       <= 1'b1;
                    end
                end
                LOAD: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (TxDone) begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end
`endif

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares the single UART transmitter between `NUM_REQ` byte producers. Each producer offers a byte with a valid/ready handshake. The arbiter grants one producer, presents the byte to the transmitter with a one-cycle `TxDataLoad` pulse, and holds off further grants until the transmitter's `TxDone` pulse. It sits between the producer blocks and the UART `TxDataLoad`/`TxDataIn`/`TxDone` ports.

## Interface
- `NUM_REQ`, default 4: number of requesters, range 2..8.
- `TIMEOUT_CYCLES`, default 16383: maximum cycles to wait for `TxDone`. Must exceed 10×1042. Used only with `UART_ARB_TIMEOUT_EN`.
- `Clock`  in  1  system clock.
- `Reset`  in  1  reset, asynchronous, active-low.
- `ReqValid`  in  `NUM_REQ`  requester k has a byte pending.
- `ReqData`  in  `8*NUM_REQ`  byte of requester k at bits [8k+7:8k].
- `ReqReady`  out  `NUM_REQ`  one-hot handshake; the byte is taken when `ReqValid[k]` and `ReqReady[k]` are both high.
- `TxDataLoad`  out  1  one-cycle load strobe to the UART.
- `TxDataIn`  out  8  byte to the UART; stable from the load cycle until done.
- `TxDone`  in  1  one-cycle pulse from the UART at the end of the stop bit.
- `GrantId`  out  `$clog2(NUM_REQ)`  index of the last granted requester.
- `Busy`  out  1  a byte is in flight (states LOAD and WAIT).
- `Timeout`  out  1  one-cycle pulse on watchdog abort; constant 0 when the feature is compiled out.

## Operation
- States:
  - IDLE: grant when any `ReqValid` is high, then go to LOAD.
  - LOAD: `TxDataLoad`=1 for exactly one cycle, then go to WAIT.
  - WAIT: wait for `TxDone`, then go to IDLE.
- Arbitration:
  - Round-robin pointer `last`. The search starts at `(last+1) mod NUM_REQ` and the first set `ReqValid` wins.
  - On a grant, `last` and `GrantId` take the winner index.
- `ReqReady` is combinational: it is high only in IDLE, only for the winner. It is all-zero in LOAD and WAIT.
- On the handshake edge, the winner's byte is latched into `TxDataIn`. `TxDataIn` holds its value until the next grant.
- `TxDone` is ignored in IDLE and LOAD.
- A requester dropping `ReqValid` before it is granted is legal; it simply loses its turn.
- `Busy` = (state != IDLE). It is registered, derived from the next state.
- Reset values:
  - outputs: `TxDataLoad`=0, `TxDataIn`=0, `GrantId`=0, `Busy`=0, `Timeout`=0, `ReqReady`=0.
  - internal: state=IDLE, `last`=`NUM_REQ-1`, so requester 0 wins first.
- Reset asserted mid-transfer: return to IDLE immediately with `TxDataLoad` low. The UART shares the same reset, so no half byte is lost silently. The interrupted byte is not re-sent.

## Timing
- Cycle t: IDLE with valid, so `ReqReady[k]`=1 and the handshake completes.
- t+1: LOAD, `TxDataLoad`=1, `TxDataIn`=byte.
- t+2 onward: WAIT.
- `TxDone` at cycle d gives IDLE at d+1, where a new grant is possible. UART idle-state sampling at d+2 accepts it.
- Back-to-back byte spacing: UART frame time + 3 cycles.
- `TxDataLoad` is never asserted while `Busy` was already high in the previous cycle.

## Configuration
- Macro `UART_ARB_TIMEOUT_EN`.
- Defined:
  - WAIT runs a 14-bit counter, cleared on entry to WAIT.
  - If the counter reaches `TIMEOUT_CYCLES-1` with no `TxDone`: pulse `Timeout` for one cycle and go to IDLE.
  - `TxDone` on the same cycle as expiry wins: normal completion, no `Timeout`.
- Undefined: WAIT lasts indefinitely, `Timeout` is tied 0 and no counter is built.

## Structure
- Package `uart_ctrl_pkg`:
  - state enum {IDLE, LOAD, WAIT}.
  - constants `CPB_9600`=1042 and `CPB_19200`=521.
  - `TIMEOUT_DEFAULT`=16383.
- Sub-module `rr_arbiter`:
  - combinational rotate-priority-select.
  - inputs: request vector, pointer.
  - outputs: one-hot grant, index, any.
- Top: FSM, data latch, watchdog.

## Test plan
- Single request: `ReqValid`=0001, `ReqData[7:0]`=0xA5 → `ReqReady`=0001 for 1 cycle; next cycle `TxDataLoad`=1 with `TxDataIn`=0xA5; `Busy` stays 1 until the cycle after `TxDone`.
- All four valid continuously → grant order 0,1,2,3,0; exactly one `TxDataLoad` per `TxDone`; `GrantId` follows that sequence.
- Requesters 1 and 3 valid with `last`=1 → 3 is granted before 1.
- `Reset` pulled low during WAIT → next cycle all outputs are at reset values; after release, requester 0 has first priority.
- With the macro, `TIMEOUT_CYCLES`=100, `TxDone` held 0 → `Timeout` pulses at WAIT cycle 100 and returns to IDLE; with `TxDone` on cycle 99 → no `Timeout`.
- Without the macro, `TxDone` withheld 20000 cycles → `Busy` stays 1, `Timeout` stays 0, no further `ReqReady`.
